// File: rtl/drum_strike_detector.sv
// Drum strike detector: watches one gyro axis for a swing that rises above THRESH,
// peaks, and falls back to RELEASE; reports the peak, a hit count and swing aborts.
module drum_strike_detector #(
    parameter logic [1:0]         AXIS        = 2'd1,
    parameter logic               NEG_POL     = 1'b0,
    parameter logic signed [15:0] THRESH      = 16'sd2000,
    parameter logic signed [15:0] RELEASE     = 16'sd500,
    parameter logic [7:0]         SWING_MAX   = 8'd64,
    parameter logic [17:0]        REFRACT_CYC = 18'd150000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        gyro_valid,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic        strike,
    output logic [15:0] strike_vel,
    output logic [7:0]  strike_count,
    output logic        swing_timeout,
    output logic        armed
);

    typedef enum logic [1:0] {IDLE, SWING, REFRACT} state_t;

    localparam logic signed [16:0] THR17 = {THRESH[15], THRESH};
    localparam logic signed [16:0] REL17 = {RELEASE[15], RELEASE};
    localparam logic [17:0]        REFRACT_LOAD = REFRACT_CYC - 18'd1;

    state_t             state, state_next;
    logic [15:0]        axis_raw;
    logic signed [16:0] v;
    logic signed [16:0] peak, peak_next, peak_upd;
    logic [7:0]         cnt, cnt_next, cnt_inc;
    logic [17:0]        ref_cnt, ref_next;
    logic               fire_strike, fire_timeout;

    always_comb begin
        case (AXIS)
            2'd0:    axis_raw = gyro_x;
            2'd1:    axis_raw = gyro_y;
            default: axis_raw = gyro_z;
        endcase
    end

    // Negating -32768 would overflow 16 bits, so it clamps to the largest positive rate.
    always_comb begin
        v = $signed({axis_raw[15], axis_raw});
        if (NEG_POL) begin
            if (axis_raw == 16'h8000) v = 17'sd32767;
            else                      v = -$signed({axis_raw[15], axis_raw});
        end
    end

    assign cnt_inc  = cnt + 8'd1;
    assign peak_upd = (v > peak) ? v : peak;

    always_comb begin
        state_next   = state;
        peak_next    = peak;
        cnt_next     = cnt;
        ref_next     = ref_cnt;
        fire_strike  = 1'b0;
        fire_timeout = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            peak_next  = '0;
            cnt_next   = '0;
            ref_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gyro_valid && v >= THR17) begin
                        state_next = SWING;
                        peak_next  = v;
                        cnt_next   = 8'd1;
                    end
                end
                SWING: begin
                    if (gyro_valid) begin
                        peak_next = peak_upd;
                        cnt_next  = cnt_inc;
                        // Release wins over timeout when both happen on one sample.
                        if (v <= REL17) begin
                            state_next  = REFRACT;
                            ref_next    = REFRACT_LOAD;
                            fire_strike = 1'b1;
                        end else if (cnt_inc == SWING_MAX) begin
                            state_next   = REFRACT;
                            ref_next     = REFRACT_LOAD;
                            fire_timeout = 1'b1;
                        end
                    end
                end
                REFRACT: begin
                    if (ref_cnt == '0) state_next = IDLE;
                    else               ref_next   = ref_cnt - 18'd1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            peak          <= '0;
            cnt           <= '0;
            ref_cnt       <= '0;
            strike        <= 1'b0;
            swing_timeout <= 1'b0;
            strike_vel    <= '0;
            strike_count  <= '0;
            armed         <= 1'b0;
        end else begin
            state         <= state_next;
            peak          <= peak_next;
            cnt           <= cnt_next;
            ref_cnt       <= ref_next;
            strike        <= fire_strike;
            swing_timeout <= fire_timeout;
            armed         <= enable && (state_next == IDLE);
            if (fire_strike) begin
                strike_vel   <= peak_upd[15:0];
                strike_count <= strike_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_drum_strike_detector.sv
// Bench for drum_strike_detector: directed swings on gyro_y (negated polarity) with a
// scoreboard of expected strike/timeout pulses checked by an independent monitor.
module tb_drum_strike_detector;

    localparam int K_STRIKE  = 1;
    localparam int K_TIMEOUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        gyro_valid = 1'b0;
    logic [15:0] gyro_x = 16'h8001;
    logic [15:0] gyro_y = 16'h0000;
    logic [15:0] gyro_z = 16'h8001;
    logic        strike;
    logic [15:0] strike_vel;
    logic [7:0]  strike_count;
    logic        swing_timeout;
    logic        armed;

    typedef struct {
        int kind;
        int cyc;
        int vel;
        int cnt;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  total = 0;
    int  passed = 0;
    int  exp_vel = 0;
    int  exp_count = 0;

    drum_strike_detector #(
        .AXIS(2'd1), .NEG_POL(1'b1), .THRESH(16'sd2000), .RELEASE(16'sd500),
        .SWING_MAX(8'd64), .REFRACT_CYC(18'd20)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .gyro_valid(gyro_valid),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .strike(strike), .strike_vel(strike_vel), .strike_count(strike_count),
        .swing_timeout(swing_timeout), .armed(armed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one sample whose polarity-corrected value is v; x/z carry a decoy.
    task automatic send(input int v);
        gyro_valid = 1'b1;
        gyro_y     = 16'(-v);
        @(posedge clk);
        #1;
        gyro_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [15:0] raw);
        gyro_valid = 1'b1;
        gyro_y     = raw;
        @(posedge clk);
        #1;
        gyro_valid = 1'b0;
    endtask

    task automatic expect_strike(input int vel);
        ev_t e;
        exp_vel   = vel;
        exp_count = (exp_count + 1) % 256;
        e.kind = K_STRIKE; e.cyc = cyc; e.vel = exp_vel; e.cnt = exp_count;
        q.push_back(e);
    endtask

    task automatic expect_timeout();
        ev_t e;
        e.kind = K_TIMEOUT; e.cyc = cyc; e.vel = exp_vel; e.cnt = exp_count;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (strike || swing_timeout)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, swing_timeout, strike}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("pulse_kind", {30'd0, swing_timeout, strike}, e.kind);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_vel", int'(strike_vel), e.vel);
                check("pulse_count", int'(strike_count), e.cnt);
            end
        end
    end

    initial begin
        tick(3);
        check("rst_strike", int'(strike), 0);
        check("rst_vel", int'(strike_vel), 0);
        check("rst_count", int'(strike_count), 0);
        check("rst_timeout", int'(swing_timeout), 0);
        check("rst_armed", int'(armed), 0);
        rst = 1'b0;
        tick(2);
        check("idle_armed", int'(armed), 1);

        // Basic swing: peak 4000 reported after the release sample.
        send(0); send(2500); send(4000); send(3000); send(400);
        expect_strike(4000);
        tick(22);

        // Threshold boundary.
        send(1999);
        check("below_thresh_armed", int'(armed), 1);
        send(0);
        check("below_thresh_armed2", int'(armed), 1);
        send(2000);
        check("at_thresh_armed", int'(armed), 0);
        send(500);
        expect_strike(2000);
        tick(22);

        // Refractory lockout ignores a large sample, then a fresh swing counts.
        send(3000); send(0);
        expect_strike(3000);
        send(5000);
        check("refract_armed", int'(armed), 0);
        send(0);
        tick(22);
        check("post_refract_armed", int'(armed), 1);
        send(5000); send(0);
        expect_strike(5000);
        tick(22);

        // Swing that never releases aborts on the 64th sample.
        for (int i = 0; i < 64; i++) send(3000);
        expect_timeout();
        tick(22);
        check("timeout_count_held", int'(strike_count), exp_count);

        // Saturated negation of the most negative sample.
        send_raw(16'h8000); send(0);
        expect_strike(32767);
        tick(22);

        // Run the hit counter around its wrap point.
        for (int i = 0; i < 250; i++) begin
            send(2100 + i); send(100);
            expect_strike(2100 + i);
            tick(22);
        end
        check("count_at_255", int'(strike_count), 255);
        send(2600); send(0);
        expect_strike(2600);
        tick(22);
        check("count_wrapped", int'(strike_count), 0);

        // Disable mid-swing: back to idle, no pulse, outputs held.
        send(3000); send(3500);
        enable = 1'b0;
        tick(1);
        check("disable_armed", int'(armed), 0);
        enable = 1'b1;
        tick(1);
        check("reenable_armed", int'(armed), 1);
        send(0);
        tick(3);
        check("disable_vel_held", int'(strike_vel), 2600);
        check("disable_count_held", int'(strike_count), 0);

        // Asynchronous reset in the middle of the lockout.
        send(3000); send(0);
        expect_strike(3000);
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("arst_vel", int'(strike_vel), 0);
        check("arst_count", int'(strike_count), 0);
        check("arst_armed", int'(armed), 0);
        check("arst_strike", int'(strike), 0);
        tick(2);
        rst = 1'b0;
        exp_vel = 0;
        exp_count = 0;
        tick(2);
        check("post_rst_armed", int'(armed), 1);
        send(2200); send(0);
        expect_strike(2200);
        tick(5);
        check("pending_events", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
